enemies_wave_controller: RTL

Sequences a formation of up to 8 enemy movers for one game. It owns the alive mask and spawns each wave. It resolves shot-vs-enemy pixel collisions into per-enemy kill pulses and broadcasts one formation-wide direction change per frame. It also arbitrates enemy firing round-robin among living enemies. It sits between the enemy mover instances, the player shot object and the score/HUD logic in the VGA top level.

---
 rtl/enemies_wave_controller.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/enemies_wave_controller.sv
// enemies_wave_controller
//
// Sequences a formation of up to NUM_ENEMIES enemy movers. Owns the alive
// mask and the wave counter, turns shot/enemy pixel overlaps into one-hot
// kill pulses (one kill per frame), broadcasts one formation-wide direction
// change per frame, and hands out fire grants round-robin among the living.
//
// Ports:
//   clk, resetN                  clock, asynchronous active-low reset
//   startOfFrame                 one-cycle pulse per VGA frame
//   startGame                    one-cycle pulse, starts/restarts a game
//   enemyDrawReq[NUM_ENEMIES]    per-enemy drawing request, current pixel
//   shotDrawReq                  player shot drawing request, current pixel
//   enemyAtEdge[NUM_ENEMIES]     enemy touches left/right screen limit
//   enemiesResetN                active-low one-cycle respawn pulse
//   shotCollision[NUM_ENEMIES]   one-hot kill pulse
//   shotHit                      retires the player shot (with any kill)
//   changeDirection              formation-wide direction flip pulse
//   fireRequest[NUM_ENEMIES]     one-hot fire grant pulse
//   aliveMask[NUM_ENEMIES]       living enemies
//   waveNumber[4]                current wave, saturates at MAX_WAVE
//   waveCleared                  pulse together with the last kill
//
// All outputs come straight from flops.

module enemies_wave_controller #(
    parameter int NUM_ENEMIES = 4,
    parameter int FIRE_PERIOD = 60,
    parameter int CLEAR_DELAY = 120,
    parameter int MAX_WAVE    = 15
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   startGame,
    input  logic [NUM_ENEMIES-1:0] enemyDrawReq,
    input  logic                   shotDrawReq,
    input  logic [NUM_ENEMIES-1:0] enemyAtEdge,
    output logic                   enemiesResetN,
    output logic [NUM_ENEMIES-1:0] shotCollision,
    output logic                   shotHit,
    output logic                   changeDirection,
    output logic [NUM_ENEMIES-1:0] fireRequest,
    output logic [NUM_ENEMIES-1:0] aliveMask,
    output logic [3:0]             waveNumber,
    output logic                   waveCleared
);

    localparam int PTR_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int FC_W  = $clog2(FIRE_PERIOD + 1);
    localparam int CC_W  = $clog2(CLEAR_DELAY + 1);

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_ENEMIES - 1);
    localparam logic [FC_W-1:0]  FIRE_LAST  = FC_W'(FIRE_PERIOD - 1);
    localparam logic [CC_W-1:0]  CLEAR_LAST = CC_W'(CLEAR_DELAY - 1);

    typedef enum logic [1:0] {IDLE, SPAWN, PLAY, CLEARED} state_t;

    state_t                 state, state_next;
    logic                   hit_lock, hit_lock_next;
    logic                   edge_seen, edge_seen_next;
    logic [FC_W-1:0]        fire_cnt, fire_cnt_next;
    logic [PTR_W-1:0]       fire_ptr, fire_ptr_next;
    logic [CC_W-1:0]        clear_cnt, clear_cnt_next;

    logic                   enemies_reset_n_next;
    logic [NUM_ENEMIES-1:0] shot_collision_next;
    logic                   shot_hit_next;
    logic                   change_direction_next;
    logic [NUM_ENEMIES-1:0] fire_request_next;
    logic [NUM_ENEMIES-1:0] alive_mask_next;
    logic [3:0]             wave_number_next;
    logic                   wave_cleared_next;

    logic                   hit_found;
    logic [NUM_ENEMIES-1:0] hit_onehot;
    logic [NUM_ENEMIES-1:0] alive_after;
    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       search_idx;

    // NOTE: every register gets one non-blocking assignment here, so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            hit_lock        <= 1'b0;
            edge_seen       <= 1'b0;
            fire_cnt        <= '0;
            fire_ptr        <= PTR_LAST;
            clear_cnt       <= '0;
            enemiesResetN   <= 1'b1;
            shotCollision   <= '0;
            shotHit         <= 1'b0;
            changeDirection <= 1'b0;
            fireRequest     <= '0;
            aliveMask       <= '0;
            waveNumber      <= '0;
            waveCleared     <= 1'b0;
        end else begin
            state           <= state_next;
            hit_lock        <= hit_lock_next;
            edge_seen       <= edge_seen_next;
            fire_cnt        <= fire_cnt_next;
            fire_ptr        <= fire_ptr_next;
            clear_cnt       <= clear_cnt_next;
            enemiesResetN   <= enemies_reset_n_next;
            shotCollision   <= shot_collision_next;
            shotHit         <= shot_hit_next;
            changeDirection <= change_direction_next;
            fireRequest     <= fire_request_next;
            aliveMask       <= alive_mask_next;
            waveNumber      <= wave_number_next;
            waveCleared     <= wave_cleared_next;
        end
    end

    always_comb begin
        // NOTE: everything written below gets a default first, so no path
        // through the case/if tree can leave a value unassigned (no latches).
        state_next            = state;
        hit_lock_next         = hit_lock;
        edge_seen_next        = edge_seen;
        fire_cnt_next         = fire_cnt;
        fire_ptr_next         = fire_ptr;
        clear_cnt_next        = clear_cnt;
        enemies_reset_n_next  = 1'b1;
        shot_collision_next   = '0;
        shot_hit_next         = 1'b0;
        change_direction_next = 1'b0;
        fire_request_next     = '0;
        alive_mask_next       = aliveMask;
        wave_number_next      = waveNumber;
        wave_cleared_next     = 1'b0;
        hit_found             = 1'b0;
        hit_onehot            = '0;
        alive_after           = aliveMask;
        grant_found           = 1'b0;
        grant_idx             = '0;
        search_idx            = '0;

        if (startGame) begin
            // Restart from any state; pulses computed this cycle are dropped.
            state_next           = SPAWN;
            wave_number_next     = '0;
            enemies_reset_n_next = 1'b0;
        end else begin
            case (state)
                IDLE: ;

                SPAWN: begin
                    state_next       = PLAY;
                    alive_mask_next  = {NUM_ENEMIES{1'b1}};
                    wave_number_next = (int'(waveNumber) >= MAX_WAVE) ? waveNumber
                                                                      : waveNumber + 4'd1;
                    hit_lock_next    = 1'b0;
                    edge_seen_next   = 1'b0;
                    fire_cnt_next    = '0;
                    fire_ptr_next    = PTR_LAST;
                    clear_cnt_next   = '0;
                end

                PLAY: begin
                    // Lowest-index living enemy under the shot pixel wins.
                    for (int i = 0; i < NUM_ENEMIES; i++) begin
                        if (!hit_found && shotDrawReq && !hit_lock &&
                            enemyDrawReq[i] && aliveMask[i]) begin
                            hit_found     = 1'b1;
                            hit_onehot[i] = 1'b1;
                        end
                    end
                    alive_after         = aliveMask & ~hit_onehot;
                    alive_mask_next     = alive_after;
                    shot_collision_next = hit_onehot;
                    shot_hit_next       = hit_found;

                    // A kill on the frame-start cycle still locks the next frame.
                    if (hit_found)
                        hit_lock_next = 1'b1;
                    else if (startOfFrame)
                        hit_lock_next = 1'b0;

                    // An edge seen on the frame-start cycle belongs to the next frame.
                    change_direction_next = startOfFrame && edge_seen;
                    edge_seen_next = (edge_seen && !startOfFrame) ||
                                     (|(enemyAtEdge & aliveMask));

                    if (startOfFrame) begin
                        if (fire_cnt == FIRE_LAST) begin
                            fire_cnt_next = '0;
                            // Cyclic search strictly after the last shooter,
                            // excluding an enemy killed this very cycle.
                            for (int k = 1; k <= NUM_ENEMIES; k++) begin
                                search_idx = PTR_W'((int'(fire_ptr) + k) % NUM_ENEMIES);
                                if (!grant_found && alive_after[search_idx]) begin
                                    grant_found = 1'b1;
                                    grant_idx   = search_idx;
                                end
                            end
                            if (grant_found) begin
                                fire_request_next[grant_idx] = 1'b1;
                                fire_ptr_next                = grant_idx;
                            end
                        end else begin
                            fire_cnt_next = fire_cnt + 1'b1;
                        end
                    end

                    if (hit_found && (alive_after == '0)) begin
                        wave_cleared_next = 1'b1;
                        state_next        = CLEARED;
                        clear_cnt_next    = '0;
                    end
                end

                CLEARED: begin
                    if (startOfFrame) begin
                        if (clear_cnt == CLEAR_LAST) begin
                            state_next           = SPAWN;
                            enemies_reset_n_next = 1'b0;
                            clear_cnt_next       = '0;
                        end else begin
                            clear_cnt_next = clear_cnt + 1'b1;
                        end
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

endmodule
